// File: rtl/iddr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iddr_pkg
//  Description : Shared definitions for the input DDR capture register:
//                target selection helper (also used by the output DDR path),
//                fill-counter depth and the pair-phase encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package iddr_pkg;

  // Number of enabled edges after reset/slip before q1/q2 carry a clean pair.
  localparam int FILL_CNT = 3;

  // Which half of the DDR cycle leads the presented pair.
  typedef enum logic {
    PHASE_RISE_FIRST = 1'b0,
    PHASE_FALL_FIRST = 1'b1
  } iddr_phase_t;

  // True for every target string that maps onto the UltraScale IO primitives.
  function automatic bit is_ultrascale(input string target);
    return (target == "ULTRASCALE")          ||
           (target == "ULTRASCALE_PLUS")     ||
           (target == "ULTRASCALE_PLUS_ES1") ||
           (target == "ULTRASCALE_PLUS_ES2");
  endfunction

endpackage : iddr_pkg
`default_nettype wire

// File: rtl/iddr_capture.sv
`default_nettype none
// ============================================================================
//  Module      : iddr_capture
//  Description : Raw DDR capture stage. Produces the pair (R_k, F_k) on
//                rise_p/fall_p after posedge k+1. Not clock-enable gated.
//  Ports       : clk    - DDR sample clock
//                rst_n  - asynchronous reset, active-low
//                d      - DDR pad data
//                rise_p - rising-edge sample, realigned to posedge
//                fall_p - falling-edge sample, realigned to posedge
//  Revision    : 1.0 - initial release
// ============================================================================
module iddr_capture #(
  parameter string TARGET = "RTL",
  parameter int    WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise_p,
  output logic [WIDTH-1:0] fall_p
);
  import iddr_pkg::*;

  // The IDDRE1 primitive is only visible when the vendor simulation/synthesis
  // library is part of the build; otherwise the cycle-equivalent flop
  // implementation is used for every target.
`ifdef IDDR_HAVE_UNISIM
  localparam bit c_have_unisim = 1'b1;
`else
  localparam bit c_have_unisim = 1'b0;
`endif

  if (is_ultrascale(TARGET) && c_have_unisim) begin : g_vendor
`ifdef IDDR_HAVE_UNISIM
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      IDDRE1 #(
        .DDR_CLK_EDGE  ("SAME_EDGE_PIPELINED"),
        .IS_CB_INVERTED(1'b0),
        .IS_C_INVERTED (1'b0),
        .SIM_DEVICE    (TARGET)
      ) u_iddre1 (
        .Q1(rise_p[i]),
        .Q2(fall_p[i]),
        .C (clk),
        .CB(~clk),
        .D (d[i]),
        .R (~rst_n)
      );
    end
`endif
  end else begin : g_rtl
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_rise_p;
    logic [WIDTH-1:0] r_fall_p;

    // Falling-edge sample is held half a cycle in r_fall, then both halves
    // are retimed together so the pair appears on one posedge.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) r_fall <= '0;
      else        r_fall <= d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rise   <= '0;
        r_rise_p <= '0;
        r_fall_p <= '0;
      end else begin
        r_rise   <= d;
        r_rise_p <= r_rise;
        r_fall_p <= r_fall;
      end
    end

    assign rise_p = r_rise_p;
    assign fall_p = r_fall_p;
  end

endmodule : iddr_capture
`default_nettype wire

// File: rtl/iddr.sv
`default_nettype none
// ============================================================================
//  Module      : iddr
//  Description : Input DDR capture register. Presents each rise/fall pair as
//                two SDR words on the rising edge, with half-cycle slip,
//                clock enable and a pipeline-filled valid flag.
//  Ports       : clk   - DDR sample clock (fabric logic on posedge)
//                rst_n - asynchronous reset, active-low
//                ce    - fabric-stage enable
//                slip  - one-cycle pulse, toggles pair phase (needs ce=1)
//                d     - DDR data from the input buffer
//                q1    - earlier-in-time word of the pair
//                q2    - later-in-time word of the pair
//                valid - q1/q2 hold a complete post-reset/post-slip pair
//  Revision    : 1.0 - initial release
// ============================================================================
module iddr #(
  parameter string TARGET = "RTL",
  parameter int    WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             slip,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             valid
);
  import iddr_pkg::*;

  localparam logic [1:0] c_cnt_full = 2'(FILL_CNT);
  localparam logic [1:0] c_cnt_last = 2'(FILL_CNT - 1);

  logic [WIDTH-1:0] w_rise_p;
  logic [WIDTH-1:0] w_fall_p;
  logic [WIDTH-1:0] w_q1_nxt;
  logic [WIDTH-1:0] w_q2_nxt;

  logic [WIDTH-1:0] r_fall_pp;
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;
  logic             r_valid;
  logic [1:0]       r_cnt;
  iddr_phase_t      r_phase;

  iddr_capture #(
    .TARGET(TARGET),
    .WIDTH (WIDTH)
  ) u_capture (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .rise_p(w_rise_p),
    .fall_p(w_fall_p)
  );

  // Fall-first pairing borrows the falling sample from the previous raw pair,
  // which r_fall_pp keeps one enabled edge behind.
  always_comb begin
    w_q1_nxt = w_rise_p;
    w_q2_nxt = w_fall_p;
    if (r_phase == PHASE_FALL_FIRST) begin
      w_q1_nxt = r_fall_pp;
      w_q2_nxt = w_rise_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_pp <= '0;
      r_q1      <= '0;
      r_q2      <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_phase   <= PHASE_RISE_FIRST;
    end else if (ce) begin
      r_fall_pp <= w_fall_p;
      // The output update on a slip edge still uses the old phase.
      r_q1      <= w_q1_nxt;
      r_q2      <= w_q2_nxt;
      if (slip) begin
        r_phase <= (r_phase == PHASE_RISE_FIRST) ? PHASE_FALL_FIRST
                                                 : PHASE_RISE_FIRST;
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        if (r_cnt != c_cnt_full) r_cnt <= r_cnt + 2'd1;
        // Rises on the edge where the counter reaches full and stays up.
        r_valid <= (r_cnt == c_cnt_last) || (r_cnt == c_cnt_full);
      end
    end
  end

  assign q1    = r_q1;
  assign q2    = r_q2;
  assign valid = r_valid;

endmodule : iddr
`default_nettype wire
